// File: rtl/button_ctrl_pkg.sv
// rtl/button_ctrl_pkg.sv - shared types and button indices for the front-panel controller
package button_ctrl_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int BTN_START_STOP = 0;
  localparam int BTN_STEP       = 1;
  localparam int BTN_MODE       = 2;

endpackage

// File: rtl/button_ctrl_fsm_if.sv
// rtl/button_ctrl_fsm_if.sv - board buttons/LEDs and CPU run/step handshake bundle
interface button_ctrl_fsm_if #(
  parameter int N_BUTTONS = 5,
  parameter int N_MODES   = 4
);

  logic [N_BUTTONS-1:0] button;
  logic                 halt;
  logic                 step_ack;
  logic                 run_en;
  logic                 step_req;
  logic [N_MODES-1:0]   mode;
  logic [N_BUTTONS-1:0] btn_press;
  logic                 led_start_stop;
  logic                 led_step;
  logic [N_MODES-1:0]   led_run;

  // Controller side: consumes buttons and CPU status, drives run control and LEDs
  modport master (
    input  button, halt, step_ack,
    output run_en, step_req, mode, btn_press, led_start_stop, led_step, led_run
  );

  // Board/CPU side
  modport slave (
    output button, halt, step_ack,
    input  run_en, step_req, mode, btn_press, led_start_stop, led_step, led_run
  );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, counter debouncer and press-pulse generator for one button
module button_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q;
  logic [DEB_W-1:0]       cnt_q;
  logic                   press_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronise the raw input, then accept a new level only after it holds for 2^DEB_W cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      press_q <= 1'b0;
      if (s == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q != {DEB_W{1'b1}}) begin
        cnt_q <= cnt_q + DEB_W'(1);
      end else begin
        stable_q <= s;
        cnt_q    <= '0;
        // Only the 0->1 transition of the debounced level is a press
        press_q  <= s;
      end
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/button_ctrl_fsm.sv
// rtl/button_ctrl_fsm.sv - front-panel run/stop/step/halt controller with one-hot run-mode selector
module button_ctrl_fsm
  import button_ctrl_pkg::*;
#(
  parameter int N_BUTTONS   = 5,
  parameter int DEB_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int N_MODES     = 4
) (
  input  logic                clk,
  input  logic                reset,
  button_ctrl_fsm_if.master   bus
);

  logic [N_BUTTONS-1:0] press;
  logic [N_BUTTONS-1:0] level_unused;

  state_t             state_q, state_d;
  logic               run_en_q;
  logic               step_req_q;
  logic [N_MODES-1:0] mode_q;
  logic               mode_ok;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_W      (DEB_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (bus.button[i]),
      .level(level_unused[i]),
      .press(press[i])
    );
  end

  // Next-state decode: halt outranks presses, start/stop outranks step
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: begin
        if (bus.halt)                       state_d = HALTED;
        else if (press[BTN_START_STOP])     state_d = RUNNING;
        else if (press[BTN_STEP])           state_d = STEPPING;
      end
      RUNNING: begin
        if (bus.halt)                       state_d = HALTED;
        else if (press[BTN_START_STOP])     state_d = STOPPED;
      end
      STEPPING: begin
        if (bus.step_ack)                   state_d = bus.halt ? HALTED : STOPPED;
      end
      HALTED: begin
        if (press[BTN_START_STOP])          state_d = STOPPED;
      end
      default:                              state_d = STOPPED;
    endcase
  end

  // Mode may only change while the CPU is not executing
  assign mode_ok = (state_q == STOPPED) || (state_q == HALTED);

  // State register with outputs registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STOPPED;
      run_en_q   <= 1'b0;
      step_req_q <= 1'b0;
      mode_q     <= N_MODES'(1);
    end else begin
      state_q    <= state_d;
      run_en_q   <= (state_d == RUNNING);
      step_req_q <= (state_d == STEPPING);
      if (press[BTN_MODE] && mode_ok) begin
        mode_q <= {mode_q[N_MODES-2:0], mode_q[N_MODES-1]};
      end
    end
  end

  assign bus.run_en         = run_en_q;
  assign bus.led_start_stop = run_en_q;
  assign bus.step_req       = step_req_q;
  assign bus.led_step       = step_req_q;
  assign bus.mode           = mode_q;
  assign bus.led_run        = mode_q;
  assign bus.btn_press      = press;

endmodule

// File: tb/tb_button_ctrl_fsm.sv
// tb/tb_button_ctrl_fsm.sv - directed self-checking bench for button_ctrl_fsm
`timescale 1ns/100ps
module tb_button_ctrl_fsm;
  import button_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;
  int   pulse_cnt [5];
  int   last_edge [5];

  button_ctrl_fsm_if #(.N_BUTTONS(5), .N_MODES(4)) bus ();

  button_ctrl_fsm #(
    .N_BUTTONS(5), .DEB_W(4), .SYNC_STAGES(2), .N_MODES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #1 clk = ~clk;

  // Advance n rising edges, sampling on the falling edge and tallying press pulses
  task automatic wait_n(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      edge_no++;
      for (int i = 0; i < 5; i++) begin
        if (bus.btn_press[i]) begin
          pulse_cnt[i]++;
          last_edge[i] = edge_no;
        end
      end
    end
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 5; i++) begin
      pulse_cnt[i] = 0;
      last_edge[i] = -1;
    end
  endtask

  // One clean press: hold 20 cycles, release 20 cycles
  task automatic press_release(input int idx);
    bus.button[idx] = 1'b1;
    wait_n(20);
    bus.button[idx] = 1'b0;
    wait_n(20);
  endtask

  task automatic test_reset();
    wait_n(3);
    checks++;
    if (bus.run_en !== 1'b0 || bus.step_req !== 1'b0 || bus.led_start_stop !== 1'b0 ||
        bus.led_step !== 1'b0 || bus.btn_press !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: run_en=%b step_req=%b led_ss=%b led_step=%b btn_press=%b, expected all 0",
               bus.run_en, bus.step_req, bus.led_start_stop, bus.led_step, bus.btn_press);
    end
    checks++;
    if (bus.mode !== 4'b0001 || bus.led_run !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mode: mode=%b led_run=%b, expected 0001", bus.mode, bus.led_run);
    end
    checks++;
    if (dut.state_q !== STOPPED) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state_q, STOPPED);
    end
    reset = 1'b0;
    wait_n(1);
    checks++;
    if (bus.run_en !== 1'b0 || dut.state_q !== STOPPED) begin
      errors++;
      $display("FAIL post_reset_idle: run_en=%b state=%0d expected 0/STOPPED", bus.run_en, dut.state_q);
    end
  endtask

  task automatic test_start_stop();
    int t0;
    clear_pulses();
    t0 = edge_no;
    bus.button[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      wait_n(1);
      if (k == 18) begin
        checks++;
        if (bus.btn_press[0] !== 1'b1 || bus.run_en !== 1'b0) begin
          errors++;
          $display("FAIL press_edge18: btn_press0=%b run_en=%b expected 1/0", bus.btn_press[0], bus.run_en);
        end
      end
      if (k == 19) begin
        checks++;
        if (bus.btn_press[0] !== 1'b0 || bus.run_en !== 1'b1) begin
          errors++;
          $display("FAIL run_edge19: btn_press0=%b run_en=%b expected 0/1", bus.btn_press[0], bus.run_en);
        end
      end
    end
    checks++;
    if (pulse_cnt[0] !== 1 || last_edge[0] !== t0 + 18) begin
      errors++;
      $display("FAIL press_once: count=%0d edge=%0d expected 1 at %0d", pulse_cnt[0], last_edge[0], t0 + 18);
    end
    bus.button[0] = 1'b0;
    wait_n(20);
    checks++;
    if (pulse_cnt[0] !== 1 || bus.run_en !== 1'b1 || bus.led_start_stop !== 1'b1) begin
      errors++;
      $display("FAIL release_no_pulse: count=%0d run_en=%b led=%b expected 1/1/1",
               pulse_cnt[0], bus.run_en, bus.led_start_stop);
    end
    press_release(0);
    checks++;
    if (bus.run_en !== 1'b0 || dut.state_q !== STOPPED || pulse_cnt[0] !== 2) begin
      errors++;
      $display("FAIL second_press_stop: run_en=%b state=%0d count=%0d expected 0/STOPPED/2",
               bus.run_en, dut.state_q, pulse_cnt[0]);
    end
  endtask

  task automatic test_bounce();
    int bad_run;
    bad_run = 0;
    clear_pulses();
    for (int j = 0; j < 8; j++) begin
      bus.button[0] = (j % 2 == 0);
      for (int c = 0; c < 5; c++) begin
        wait_n(1);
        if (bus.run_en !== 1'b0) bad_run++;
      end
    end
    bus.button[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      wait_n(1);
      if (bus.run_en !== 1'b0) bad_run++;
    end
    checks++;
    if (pulse_cnt[0] !== 0) begin
      errors++;
      $display("FAIL bounce_pulse: got %0d pulses expected 0", pulse_cnt[0]);
    end
    checks++;
    if (bad_run !== 0) begin
      errors++;
      $display("FAIL bounce_run_en: run_en high on %0d cycles expected 0", bad_run);
    end
  endtask

  task automatic test_step();
    bus.button[1] = 1'b1;
    wait_n(19);
    checks++;
    if (bus.step_req !== 1'b1 || bus.led_step !== 1'b1 || dut.state_q !== STEPPING) begin
      errors++;
      $display("FAIL step_req_set: step_req=%b led_step=%b state=%0d expected 1/1/STEPPING",
               bus.step_req, bus.led_step, dut.state_q);
    end
    wait_n(2);
    checks++;
    if (bus.step_req !== 1'b1) begin
      errors++;
      $display("FAIL step_req_hold: step_req=%b expected 1", bus.step_req);
    end
    bus.step_ack = 1'b1;
    wait_n(1);
    bus.step_ack = 1'b0;
    checks++;
    if (bus.step_req !== 1'b0 || bus.led_step !== 1'b0 || dut.state_q !== STOPPED) begin
      errors++;
      $display("FAIL step_ack_done: step_req=%b led_step=%b state=%0d expected 0/0/STOPPED",
               bus.step_req, bus.led_step, dut.state_q);
    end
    bus.button[1] = 1'b0;
    wait_n(20);
    press_release(0);
    press_release(1);
    checks++;
    if (bus.step_req !== 1'b0 || bus.run_en !== 1'b1) begin
      errors++;
      $display("FAIL step_in_running: step_req=%b run_en=%b expected 0/1", bus.step_req, bus.run_en);
    end
  endtask

  task automatic test_mode();
    logic [3:0] exp_mode [4];
    exp_mode = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    press_release(2);
    checks++;
    if (bus.mode !== 4'b0001 || bus.run_en !== 1'b1) begin
      errors++;
      $display("FAIL mode_in_running: mode=%b run_en=%b expected 0001/1", bus.mode, bus.run_en);
    end
    press_release(0);
    for (int m = 0; m < 4; m++) begin
      press_release(2);
      checks++;
      if (bus.led_run !== exp_mode[m] || bus.mode !== exp_mode[m]) begin
        errors++;
        $display("FAIL mode_rotate_%0d: mode=%b led_run=%b expected %b", m, bus.mode, bus.led_run, exp_mode[m]);
      end
    end
  endtask

  task automatic test_halt();
    press_release(0);
    bus.button[0] = 1'b1;
    wait_n(18);
    checks++;
    if (bus.btn_press[0] !== 1'b1 || bus.run_en !== 1'b1) begin
      errors++;
      $display("FAIL halt_setup: btn_press0=%b run_en=%b expected 1/1", bus.btn_press[0], bus.run_en);
    end
    bus.halt = 1'b1;
    wait_n(1);
    checks++;
    if (dut.state_q !== HALTED || bus.run_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_wins: state=%0d run_en=%b expected HALTED/0", dut.state_q, bus.run_en);
    end
    bus.button[0] = 1'b0;
    wait_n(20);
    bus.button[0] = 1'b1;
    wait_n(19);
    checks++;
    if (dut.state_q !== STOPPED || bus.run_en !== 1'b0) begin
      errors++;
      $display("FAIL halted_to_stopped: state=%0d run_en=%b expected STOPPED/0", dut.state_q, bus.run_en);
    end
    bus.halt = 1'b0;
    bus.button[0] = 1'b0;
    wait_n(20);
    checks++;
    if (dut.state_q !== STOPPED) begin
      errors++;
      $display("FAIL halt_release_stopped: state=%0d expected STOPPED", dut.state_q);
    end
  endtask

  task automatic test_reset_mid();
    press_release(2);
    checks++;
    if (bus.mode !== 4'b0010) begin
      errors++;
      $display("FAIL mid_mode_setup: mode=%b expected 0010", bus.mode);
    end
    bus.button[1] = 1'b1;
    wait_n(19);
    checks++;
    if (bus.step_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_step_setup: step_req=%b expected 1", bus.step_req);
    end
    reset = 1'b1;
    bus.button[1] = 1'b0;
    wait_n(1);
    reset = 1'b0;
    checks++;
    if (bus.step_req !== 1'b0 || dut.state_q !== STOPPED || bus.mode !== 4'b0001 || bus.led_run !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset: step_req=%b state=%0d mode=%b led_run=%b expected 0/STOPPED/0001/0001",
               bus.step_req, dut.state_q, bus.mode, bus.led_run);
    end
    bus.step_ack = 1'b1;
    wait_n(1);
    bus.step_ack = 1'b0;
    wait_n(20);
    checks++;
    if (dut.state_q !== STOPPED || bus.step_req !== 1'b0 || bus.run_en !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_ignored: state=%0d step_req=%b run_en=%b expected STOPPED/0/0",
               dut.state_q, bus.step_req, bus.run_en);
    end
  endtask

  initial begin
    bus.button   = '0;
    bus.halt     = 1'b0;
    bus.step_ack = 1'b0;
    clear_pulses();
    test_reset();
    test_start_stop();
    test_bounce();
    test_step();
    test_mode();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
